// File: rtl/jp_pkg.sv
// Shared constants for the NES joypad emulator: button indices and shifter limits.
package jp_pkg;

    localparam int JP_BTN_A      = 0;
    localparam int JP_BTN_B      = 1;
    localparam int JP_BTN_SELECT = 2;
    localparam int JP_BTN_START  = 3;
    localparam int JP_BTN_UP     = 4;
    localparam int JP_BTN_DOWN   = 5;
    localparam int JP_BTN_LEFT   = 6;
    localparam int JP_BTN_RIGHT  = 7;

    localparam int JP_NUM_BTNS = 8;

    // Shift count at which the pad reports 1 forever, as an official pad does.
    localparam logic [3:0] JP_SHIFT_DONE = 4'd8;

endpackage

// File: rtl/jp_pad_emu_if.sv
// Joypad port between the rp2a03 (master: clock/latch) and the pad (slave: data).
interface jp_pad_emu_if;

    logic jp_clk_in;
    logic jp_latch_in;
    logic jp_data_out;

    modport master (
        output jp_clk_in,
        output jp_latch_in,
        input  jp_data_out
    );

    modport slave (
        input  jp_clk_in,
        input  jp_latch_in,
        output jp_data_out
    );

endinterface

// File: rtl/jp_pad_emu_debounce.sv
// One button: 2-flop synchronizer followed by a stable-bit debouncer that
// only accepts a change held for DEBOUNCE_CYCLES consecutive cycles.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic d_in,
    output logic q_out
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_r;
    logic          sync2_r;
    logic          stable_r;
    logic [CW-1:0] count_r;
    logic          stable_s;
    logic [CW-1:0] count_s;

    // Synchronizer chain for the asynchronous button level.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= d_in;
            sync2_r <= sync1_r;
        end
    end

    // Any cycle that agrees with the stable bit restarts the count, so short glitches are dropped.
    always_comb begin
        stable_s = stable_r;
        count_s  = count_r;
        if (sync2_r == stable_r) begin
            count_s = {CW{1'b0}};
        end else if (count_r == CNT_LAST) begin
            stable_s = ~stable_r;
            count_s  = {CW{1'b0}};
        end else begin
            count_s = count_r + {{(CW-1){1'b0}}, 1'b1};
        end
    end

    // Debounce state registers.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            stable_r <= 1'b0;
            count_r  <= {CW{1'b0}};
        end else begin
            stable_r <= stable_s;
            count_r  <= count_s;
        end
    end

    assign q_out = stable_r;

endmodule

// File: rtl/jp_pad_emu.sv
// NES standard-controller emulator: debounced buttons presented on the
// rp2a03 joypad port as the latch/clock serial shift register of a real pad.
module jp_pad_emu
    import jp_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic [JP_NUM_BTNS-1:0] btn_in,
    jp_pad_emu_if.slave            jp,
    output logic [JP_NUM_BTNS-1:0] btn_state_out
);

    logic                   jp_clk_q;
    logic                   clk_rise_s;
    logic [JP_NUM_BTNS-1:0] shreg_r;
    logic [3:0]             cnt_r;
    logic [JP_NUM_BTNS-1:0] shreg_s;
    logic [3:0]             cnt_s;

    for (genvar i = 0; i < JP_NUM_BTNS; i++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk_in (clk_in),
            .rst_in (rst_in),
            .d_in   (btn_in[i]),
            .q_out  (btn_state_out[i])
        );
    end

    assign clk_rise_s = jp.jp_clk_in & ~jp_clk_q;

    // Latch reloads every cycle and wins over a coincident clock rise;
    // debounce changes reach shreg only through a reload.
    always_comb begin
        shreg_s = shreg_r;
        cnt_s   = cnt_r;
        if (jp.jp_latch_in) begin
            shreg_s = btn_state_out;
            cnt_s   = 4'd0;
        end else if (clk_rise_s && (cnt_r != JP_SHIFT_DONE)) begin
            shreg_s = {1'b0, shreg_r[JP_NUM_BTNS-1:1]};
            cnt_s   = cnt_r + 4'd1;
        end else begin
            shreg_s = shreg_r;
            cnt_s   = cnt_r;
        end
    end

    // Edge-detect and shifter registers.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            jp_clk_q <= 1'b0;
            shreg_r  <= {JP_NUM_BTNS{1'b0}};
            cnt_r    <= 4'd0;
        end else begin
            jp_clk_q <= jp.jp_clk_in;
            shreg_r  <= shreg_s;
            cnt_r    <= cnt_s;
        end
    end

    assign jp.jp_data_out = (cnt_r == JP_SHIFT_DONE) ? 1'b1 : shreg_r[0];

endmodule

// File: tb/tb_jp_pad_emu.sv
// Directed self-checking bench for jp_pad_emu with DEBOUNCE_CYCLES=4.
module tb_jp_pad_emu;

    logic       clk_in;
    logic       rst_in;
    logic [7:0] btn_in;
    logic [7:0] btn_state_out;
    int         total;
    int         bad;

    jp_pad_emu_if bus ();

    jp_pad_emu #(
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .btn_in        (btn_in),
        .jp            (bus),
        .btn_state_out (btn_state_out)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_in);
            #1;
        end
    endtask

    task automatic latch_pulse();
        bus.jp_latch_in = 1'b1;
        tick(1);
        bus.jp_latch_in = 1'b0;
        tick(1);
    endtask

    task automatic clk_pulse();
        bus.jp_clk_in = 1'b1;
        tick(2);
        bus.jp_clk_in = 1'b0;
        tick(3);
    endtask

    task automatic test_reset();
        rst_in = 1'b1;
        btn_in = 8'hFF;
        bus.jp_clk_in = 1'b0;
        bus.jp_latch_in = 1'b0;
        for (int c = 0; c < 4; c++) begin
            if (c == 3) rst_in = 1'b0;
            tick(1);
            total++;
            if (bus.jp_data_out !== 1'b0 || btn_state_out !== 8'h00) begin
                bad++;
                $display("FAIL reset cycle %0d: data=%b state=%h, need data=0 state=00", c, bus.jp_data_out, btn_state_out);
            end
        end
        btn_in = 8'h00;
        tick(10);
    endtask

    task automatic test_debounce();
        btn_in = 8'h09;
        tick(5);
        total++;
        if (btn_state_out !== 8'h00) begin
            bad++;
            $display("FAIL debounce_early: state=%h, need 00", btn_state_out);
        end
        tick(1);
        total++;
        if (btn_state_out !== 8'h09) begin
            bad++;
            $display("FAIL debounce_press: state=%h, need 09", btn_state_out);
        end
        btn_in = 8'h89;
        tick(3);
        btn_in = 8'h09;
        for (int c = 0; c < 8; c++) begin
            tick(1);
            total++;
            if (btn_state_out !== 8'h09) begin
                bad++;
                $display("FAIL debounce_glitch cycle %0d: state=%h, need 09", c, btn_state_out);
            end
        end
    endtask

    task automatic test_serial();
        logic [10:0] exp_seq;
        exp_seq = 11'b111_0000_1001; // bit i = expected read i
        latch_pulse();
        for (int k = 0; k < 11; k++) begin
            if (k > 0) clk_pulse();
            total++;
            if (bus.jp_data_out !== exp_seq[k]) begin
                bad++;
                $display("FAIL serial read %0d: data=%b, need %b", k, bus.jp_data_out, exp_seq[k]);
            end
        end
    endtask

    task automatic test_latch_priority();
        logic [7:0] exp_seq;
        exp_seq = 8'b1000_0100; // B,Sel,Start,Up,Down,Left,Right,done
        latch_pulse();
        clk_pulse();
        clk_pulse();
        clk_pulse();
        bus.jp_latch_in = 1'b1;
        bus.jp_clk_in = 1'b1;
        tick(2);
        bus.jp_latch_in = 1'b0;
        tick(2);
        total++;
        if (bus.jp_data_out !== 1'b1) begin
            bad++;
            $display("FAIL latch_priority A: data=%b, need 1", bus.jp_data_out);
        end
        bus.jp_clk_in = 1'b0;
        tick(2);
        for (int k = 0; k < 8; k++) begin
            clk_pulse();
            total++;
            if (bus.jp_data_out !== exp_seq[k]) begin
                bad++;
                $display("FAIL latch_priority read %0d: data=%b, need %b", k + 1, bus.jp_data_out, exp_seq[k]);
            end
        end
    endtask

    task automatic test_held_clock();
        latch_pulse();
        bus.jp_clk_in = 1'b1;
        tick(20);
        total++;
        if (bus.jp_data_out !== 1'b0) begin
            bad++;
            $display("FAIL held_clock B: data=%b, need 0", bus.jp_data_out);
        end
        bus.jp_clk_in = 1'b0;
        tick(3);
        clk_pulse();
        total++;
        if (bus.jp_data_out !== 1'b0) begin
            bad++;
            $display("FAIL held_clock Select: data=%b, need 0", bus.jp_data_out);
        end
        clk_pulse();
        total++;
        if (bus.jp_data_out !== 1'b1) begin
            bad++;
            $display("FAIL held_clock Start: data=%b, need 1", bus.jp_data_out);
        end
    endtask

    task automatic test_coherency();
        latch_pulse();
        clk_pulse();
        btn_in = 8'h0B;
        tick(7);
        total++;
        if (btn_state_out !== 8'h0B) begin
            bad++;
            $display("FAIL coherency state: state=%h, need 0b", btn_state_out);
        end
        total++;
        if (bus.jp_data_out !== 1'b0) begin
            bad++;
            $display("FAIL coherency old B: data=%b, need 0", bus.jp_data_out);
        end
        clk_pulse();
        total++;
        if (bus.jp_data_out !== 1'b0) begin
            bad++;
            $display("FAIL coherency Select: data=%b, need 0", bus.jp_data_out);
        end
        clk_pulse();
        total++;
        if (bus.jp_data_out !== 1'b1) begin
            bad++;
            $display("FAIL coherency Start: data=%b, need 1", bus.jp_data_out);
        end
        latch_pulse();
        clk_pulse();
        total++;
        if (bus.jp_data_out !== 1'b1) begin
            bad++;
            $display("FAIL coherency new B: data=%b, need 1", bus.jp_data_out);
        end
    endtask

    task automatic test_reset_mid();
        rst_in = 1'b1;
        tick(1);
        rst_in = 1'b0;
        total++;
        if (bus.jp_data_out !== 1'b0 || btn_state_out !== 8'h00) begin
            bad++;
            $display("FAIL reset_mid: data=%b state=%h, need data=0 state=00", bus.jp_data_out, btn_state_out);
        end
        clk_pulse();
        total++;
        if (bus.jp_data_out !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid no_latch: data=%b, need 0", bus.jp_data_out);
        end
        tick(3);
        total++;
        if (btn_state_out !== 8'h0B) begin
            bad++;
            $display("FAIL reset_mid state: state=%h, need 0b", btn_state_out);
        end
        latch_pulse();
        total++;
        if (bus.jp_data_out !== 1'b1) begin
            bad++;
            $display("FAIL reset_mid relatch A: data=%b, need 1", bus.jp_data_out);
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        test_reset();
        test_debounce();
        test_serial();
        test_latch_priority();
        test_held_clock();
        test_coherency();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
